// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register. It updates on the falling clock edge and counts retired instructions.
// Define MEM_WB_FWD_EN to build the WB->EX forwarding comparators and their ports.
module mem_wb_stage #(
  parameter int DATA_W   = 8,
  parameter int REG_AW   = 4,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        wb_ctrl,
  input  logic [DATA_W-1:0] mem_out,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [REG_AW-1:0] dst_reg,
`ifdef MEM_WB_FWD_EN
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic              fwd_a,
  output logic              fwd_b,
`endif
  output logic              out_valid,
  output logic [REG_AW-1:0] dst_reg_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] mem_out_o,
  output logic              mem_to_reg_o,
  output logic              reg_write_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [15:0]       retire_cnt
);

  logic reg_write_r;
  logic dst_ok;

  // A flush clears only the control bits and leaves the data/address registers holding their values.
  // The write bit is gated by in_valid so that junk on idle cycles never reaches the register file.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      mem_to_reg_o <= 1'b0;
      reg_write_r  <= 1'b0;
      dst_reg_o    <= '0;
      alu_o        <= '0;
      mem_out_o    <= '0;
      retire_cnt   <= '0;
    end else if (flush) begin
      out_valid    <= 1'b0;
      mem_to_reg_o <= 1'b0;
      reg_write_r  <= 1'b0;
    end else if (!stall) begin
      out_valid    <= in_valid;
      mem_to_reg_o <= wb_ctrl[1];
      reg_write_r  <= in_valid & wb_ctrl[0];
      dst_reg_o    <= dst_reg;
      alu_o        <= alu_result;
      mem_out_o    <= mem_out;
      if (in_valid)
        retire_cnt <= retire_cnt + 16'd1;
    end
  end

  assign dst_ok      = (ZERO_REG == 0) || (dst_reg_o != '0);
  assign reg_write_o = reg_write_r & out_valid & dst_ok;
  assign wb_data_o   = mem_to_reg_o ? mem_out_o : alu_o;

`ifdef MEM_WB_FWD_EN
  assign fwd_a = reg_write_o & (dst_reg_o == rs1_addr);
  assign fwd_b = reg_write_o & (dst_reg_o == rs2_addr);
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage. It runs a directed vector table, a mid-cycle reset, a forwarding
// sequence when it is built, random traffic checked against a reference model, and a retire counter wrap.
module tb_mem_wb_stage;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b1;
  logic          rst, stall, flush, in_valid;
  logic [1:0]    wb_ctrl;
  logic [DW-1:0] mem_out, alu_result;
  logic [AW-1:0] dst_reg;

  logic          out_valid, mem_to_reg_o, reg_write_o;
  logic [AW-1:0] dst_reg_o;
  logic [DW-1:0] alu_o, mem_out_o, wb_data_o;
  logic [15:0]   retire_cnt;

  logic          out_valid0, mem_to_reg_o0, reg_write_o0;
  logic [AW-1:0] dst_reg_o0;
  logic [DW-1:0] alu_o0, mem_out_o0, wb_data_o0;
  logic [15:0]   retire_cnt0;

`ifdef MEM_WB_FWD_EN
  logic [AW-1:0] rs1_addr = '0, rs2_addr = '0;
  logic          fwd_a, fwd_b, fwd_a0, fwd_b0;
`endif

  // Two instances share the stimulus: the main one drops writes to r0, the other one does not.
  mem_wb_stage #(.DATA_W(DW), .REG_AW(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .wb_ctrl(wb_ctrl), .mem_out(mem_out), .alu_result(alu_result), .dst_reg(dst_reg),
`ifdef MEM_WB_FWD_EN
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .fwd_a(fwd_a), .fwd_b(fwd_b),
`endif
    .out_valid(out_valid), .dst_reg_o(dst_reg_o), .alu_o(alu_o), .mem_out_o(mem_out_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o), .wb_data_o(wb_data_o),
    .retire_cnt(retire_cnt)
  );

  mem_wb_stage #(.DATA_W(DW), .REG_AW(AW), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .wb_ctrl(wb_ctrl), .mem_out(mem_out), .alu_result(alu_result), .dst_reg(dst_reg),
`ifdef MEM_WB_FWD_EN
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .fwd_a(fwd_a0), .fwd_b(fwd_b0),
`endif
    .out_valid(out_valid0), .dst_reg_o(dst_reg_o0), .alu_o(alu_o0), .mem_out_o(mem_out_o0),
    .mem_to_reg_o(mem_to_reg_o0), .reg_write_o(reg_write_o0), .wb_data_o(wb_data_o0),
    .retire_cnt(retire_cnt0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // The reference model keeps the last accepted instruction as a record plus a plain retire tally.
  logic          m_valid, m_m2r, m_rw;
  logic [AW-1:0] m_dst;
  logic [DW-1:0] m_alu, m_mem;
  int            m_cnt;

  typedef struct {
    logic          st, fl, v;
    logic [1:0]    ctrl;
    logic [DW-1:0] mo, alu;
    logic [AW-1:0] dst;
    logic [DW-1:0] e_wb;
    logic          e_rw, e_rw0, e_v;
    logic [15:0]   e_cnt;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic modelReset();
    m_valid = 1'b0; m_m2r = 1'b0; m_rw = 1'b0;
    m_dst = '0; m_alu = '0; m_mem = '0; m_cnt = 0;
  endtask

  task automatic applyStimulus(input logic st, input logic fl, input logic v, input logic [1:0] ctrl,
                               input logic [DW-1:0] mo, input logic [DW-1:0] alu, input logic [AW-1:0] dst);
    @(posedge clk);
    stall = st; flush = fl; in_valid = v; wb_ctrl = ctrl;
    mem_out = mo; alu_result = alu; dst_reg = dst;
    if (fl) begin
      m_valid = 1'b0; m_m2r = 1'b0; m_rw = 1'b0;
    end else if (!st) begin
      m_valid = v; m_m2r = ctrl[1]; m_rw = ctrl[0];
      m_dst = dst; m_alu = alu; m_mem = mo;
      if (v) m_cnt = (m_cnt + 1) % 65536;
    end
    @(negedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag);
    logic e_rw0, e_rw;
    e_rw0 = m_rw && m_valid;
    e_rw  = e_rw0 && (m_dst != '0);
    check({tag, ".out_valid"},   32'(out_valid),    32'(m_valid));
    check({tag, ".reg_write"},   32'(reg_write_o),  32'(e_rw));
    check({tag, ".reg_write0"},  32'(reg_write_o0), 32'(e_rw0));
    check({tag, ".mem_to_reg"},  32'(mem_to_reg_o), 32'(m_m2r));
    check({tag, ".dst_reg"},     32'(dst_reg_o),    32'(m_dst));
    check({tag, ".alu"},         32'(alu_o),        32'(m_alu));
    check({tag, ".mem_out"},     32'(mem_out_o),    32'(m_mem));
    check({tag, ".wb_data"},     32'(wb_data_o),    32'(m_m2r ? m_mem : m_alu));
    check({tag, ".retire_cnt"},  32'(retire_cnt),   32'(m_cnt));
`ifdef MEM_WB_FWD_EN
    rs1_addr = 4'($urandom);
    rs2_addr = ($urandom_range(0, 1) == 0) ? m_dst : 4'($urandom);
    #1;
    check({tag, ".fwd_a"},  32'(fwd_a),  32'(e_rw && (m_dst == rs1_addr)));
    check({tag, ".fwd_b"},  32'(fwd_b),  32'(e_rw && (m_dst == rs2_addr)));
    check({tag, ".fwd_b0"}, 32'(fwd_b0), 32'(e_rw0 && (m_dst == rs2_addr)));
`endif
  endtask

  initial begin
    // Directed vectors, in order, starting from the reset state.
    tbl[0] = '{1'b0, 1'b0, 1'b1, 2'b11, 8'h5A, 8'h33, 4'd3, 8'h5A, 1'b1, 1'b1, 1'b1, 16'd1};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 2'b01, 8'h5A, 8'h33, 4'd3, 8'h33, 1'b1, 1'b1, 1'b1, 16'd2};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 2'b10, 8'h11, 8'h22, 4'd7, 8'h33, 1'b1, 1'b1, 1'b1, 16'd2};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 2'b11, 8'h12, 8'h23, 4'd8, 8'h33, 1'b1, 1'b1, 1'b1, 16'd2};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 2'b00, 8'h13, 8'h24, 4'd9, 8'h33, 1'b1, 1'b1, 1'b1, 16'd2};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 2'b11, 8'hAA, 8'hBB, 4'd9, 8'h33, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 2'b01, 8'h44, 8'h55, 4'd0, 8'h55, 1'b0, 1'b1, 1'b1, 16'd3};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 2'b11, 8'h66, 8'h77, 4'd5, 8'h66, 1'b0, 1'b0, 1'b0, 16'd3};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 2'b00, 8'h01, 8'h02, 4'd2, 8'h02, 1'b0, 1'b0, 1'b1, 16'd4};

    rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; wb_ctrl = 2'b00;
    mem_out = '0; alu_result = '0; dst_reg = '0;
    modelReset();
    #3;
    checkOutput("reset");
    #4;
    rst = 1'b0;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].st, tbl[i].fl, tbl[i].v, tbl[i].ctrl, tbl[i].mo, tbl[i].alu, tbl[i].dst);
      check($sformatf("vec%0d.wb_data", i),    32'(wb_data_o),    32'(tbl[i].e_wb));
      check($sformatf("vec%0d.reg_write", i),  32'(reg_write_o),  32'(tbl[i].e_rw));
      check($sformatf("vec%0d.reg_write0", i), 32'(reg_write_o0), 32'(tbl[i].e_rw0));
      check($sformatf("vec%0d.out_valid", i),  32'(out_valid),    32'(tbl[i].e_v));
      check($sformatf("vec%0d.retire_cnt", i), 32'(retire_cnt),   32'(tbl[i].e_cnt));
    end

    // Reset is asserted between clock edges while a valid instruction sits in WB.
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, 8'hC3, 8'h3C, 4'd6);
    check("pre_rst.out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    stall = 1'b1; flush = 1'b1; in_valid = 1'b1;
    modelReset();
    #1;
    checkOutput("async_rst");
    @(negedge clk);
    #2;
    checkOutput("rst_dominates");
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 8'h10, 8'h20, 4'd4);
    checkOutput("post_rst_first");

`ifdef MEM_WB_FWD_EN
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 8'h00, 8'h99, 4'd5);
    rs1_addr = 4'd5; rs2_addr = 4'd6;
    #1;
    check("fwd_seq.fwd_a", 32'(fwd_a), 32'd1);
    check("fwd_seq.fwd_b", 32'(fwd_b), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b01, 8'h00, 8'h99, 4'd5);
    rs1_addr = 4'd5;
    #1;
    check("fwd_flush.fwd_a", 32'(fwd_a), 32'd0);
`endif

    for (int n = 0; n < 300; n++) begin
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                    2'($urandom), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom));
      checkOutput($sformatf("rand%0d", n));
    end

    // Retire back-to-back until the counter reaches its top value, then roll it over.
    while (m_cnt != 65535)
      applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 8'($urandom), 8'($urandom), 4'($urandom));
    check("wrap.top", 32'(retire_cnt), 32'h0000_FFFF);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 8'h01, 8'h02, 4'd1);
    check("wrap.zero", 32'(retire_cnt), 32'h0000_0000);
    checkOutput("wrap.state");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
